pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage MIPS-subset core.
- Generates PC source, stage write-enables and flushes from ID/EX/MEM opcodes: branch-taken squash, jump redirect, load-use bubble, data-memory wait freeze.
- Adds boot hold after reset, a memory-timeout error state and a stall performance counter.
- Sits beside the PC mux and pipeline registers; supersedes standalone PC-source logic.

---
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: PC source, stage write-enables and flushes for the
// 5-stage core, with boot hold, data-memory wait freeze, timeout error and stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned BOOT_CYC    = 2,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic [4:0]       Rs,
    input  logic [4:0]       Rt,
    input  logic [5:0]       eOp,
    input  logic [4:0]       eRt,
    input  logic             eZ,
    input  logic [5:0]       mOp,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic [1:0]       Pcsrc,
    output logic             PcWr,
    output logic             IfIdWr,
    output logic             IfIdFlush,
    output logic             IdExWr,
    output logic             IdExFlush,
    output logic             ExMemWr,
    output logic             MemWbFlush,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned BOOT_W = 8;
    localparam int unsigned WAIT_W = 8;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_MWAIT = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t              r_state;
    logic [BOOT_W-1:0]   r_boot_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic w_memop;
    logic w_taken;
    logic w_load_use;
    logic w_jump;
    logic w_frozen;

    // Hazard detection and control decode (0-cycle latency from inputs)
    always_comb begin
        w_memop    = (mOp == OP_LW) || (mOp == OP_SW);
        w_taken    = ((eOp == OP_BEQ) && eZ) || ((eOp == OP_BNE) && !eZ);
        w_load_use = (eOp == OP_LW) && (eRt != 5'd0) &&
                     ((eRt == Rs) ||
                      ((eRt == Rt) && ((Op == OP_RTYPE) || (Op == OP_BEQ) ||
                                       (Op == OP_BNE) || (Op == OP_SW))));
        w_jump     = (Op == OP_J);
        w_frozen   = 1'b0;

        dmem_req   = 1'b0;
        Pcsrc      = PC_SEQ;
        PcWr       = 1'b1;
        IfIdWr     = 1'b1;
        IfIdFlush  = 1'b0;
        IdExWr     = 1'b1;
        IdExFlush  = 1'b0;
        ExMemWr    = 1'b1;
        MemWbFlush = 1'b0;

        case (r_state)
            S_BOOT: begin
                PcWr       = 1'b0;
                IfIdWr     = 1'b0;
                IdExWr     = 1'b0;
                ExMemWr    = 1'b0;
                IfIdFlush  = 1'b1;
                IdExFlush  = 1'b1;
                MemWbFlush = 1'b1;
            end
            S_RUN: begin
                dmem_req = w_memop;
                w_frozen = w_memop && !dmem_ack;
            end
            S_MWAIT: begin
                dmem_req = w_memop;
                w_frozen = !dmem_ack;
            end
            S_ERR: begin
                w_frozen = 1'b1;
            end
        endcase

        if (w_frozen) begin
            PcWr       = 1'b0;
            IfIdWr     = 1'b0;
            IdExWr     = 1'b0;
            ExMemWr    = 1'b0;
            MemWbFlush = 1'b1;
        end else if ((r_state == S_RUN) || (r_state == S_MWAIT)) begin
            if (w_taken) begin
                Pcsrc     = PC_BR;
                IfIdFlush = 1'b1;
                IdExFlush = 1'b1;
            end else if (w_load_use) begin
                PcWr      = 1'b0;
                IfIdWr    = 1'b0;
                IdExFlush = 1'b1;
            end else if (w_jump) begin
                Pcsrc     = PC_JMP;
                IfIdFlush = 1'b1;
            end
        end
    end

    assign err       = (r_state == S_ERR);
    assign stall_cnt = r_stall_cnt;

    // Sequencer state, boot/wait counters and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_boot_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (((r_state == S_RUN) || (r_state == S_MWAIT)) && !PcWr &&
                (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end

            case (r_state)
                S_BOOT: begin
                    if (32'(r_boot_cnt) + 32'd1 >= BOOT_CYC) begin
                        r_state    <= S_RUN;
                        r_boot_cnt <= '0;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + BOOT_W'(1);
                    end
                end
                S_RUN: begin
                    if (w_memop && !dmem_ack) begin
                        r_state    <= S_MWAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                S_MWAIT: begin
                    if (dmem_ack) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end else if (32'(r_wait_cnt) >= MEM_TIMEOUT) begin
                        r_state    <= S_ERR;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan steps followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned BOOT_CYC    = 2;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 4;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       Op, eOp, mOp;
    logic [4:0]       Rs, Rt, eRt;
    logic             eZ, dmem_ack;
    logic             dmem_req, PcWr, IfIdWr, IfIdFlush, IdExWr, IdExFlush;
    logic             ExMemWr, MemWbFlush, err;
    logic [1:0]       Pcsrc;
    logic [CNT_W-1:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: remaining boot cycles, wait cycles so far (0 = not waiting), error flag
    int m_boot_left;
    int m_waited;
    bit m_err;
    int m_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .BOOT_CYC   (BOOT_CYC),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .Rs         (Rs),
        .Rt         (Rt),
        .eOp        (eOp),
        .eRt        (eRt),
        .eZ         (eZ),
        .mOp        (mOp),
        .dmem_ack   (dmem_ack),
        .dmem_req   (dmem_req),
        .Pcsrc      (Pcsrc),
        .PcWr       (PcWr),
        .IfIdWr     (IfIdWr),
        .IfIdFlush  (IfIdFlush),
        .IdExWr     (IdExWr),
        .IdExFlush  (IdExFlush),
        .ExMemWr    (ExMemWr),
        .MemWbFlush (MemWbFlush),
        .err        (err),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    // Expected {dmem_req, Pcsrc, PcWr, IfIdWr, IfIdFlush, IdExWr, IdExFlush, ExMemWr, MemWbFlush, err}
    function automatic logic [10:0] model_ctrl();
        logic memop, taken, lu, jmp, rt_user;
        memop   = (mOp == OP_LW) || (mOp == OP_SW);
        taken   = ((eOp == OP_BEQ) && eZ) || ((eOp == OP_BNE) && !eZ);
        rt_user = (Op == OP_R) || (Op == OP_BEQ) || (Op == OP_BNE) || (Op == OP_SW);
        lu      = (eOp == OP_LW) && (eRt != 5'd0) && ((eRt == Rs) || ((eRt == Rt) && rt_user));
        jmp     = (Op == OP_J);
        if (m_boot_left > 0)                       return {1'b0,  10'b00_0010_1010};
        if (m_err)                                 return {1'b0,  10'b00_0000_0011};
        if (!dmem_ack && ((m_waited > 0) || memop)) return {memop, 10'b00_0000_0010};
        if (taken)                                 return {memop, 10'b10_1111_1100};
        if (lu)                                    return {memop, 10'b00_0001_1100};
        if (jmp)                                   return {memop, 10'b11_1111_0100};
        return {memop, 10'b00_1101_0100};
    endfunction

    task automatic model_reset();
        m_boot_left = BOOT_CYC;
        m_waited    = 0;
        m_err       = 1'b0;
        m_cnt       = 0;
    endtask

    task automatic model_clock(input logic pcwr_exp);
        logic memop;
        memop = (mOp == OP_LW) || (mOp == OP_SW);
        if (rst) begin
            model_reset();
        end else if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (!m_err) begin
            if (!pcwr_exp && (m_cnt < (1 << CNT_W) - 1)) m_cnt++;
            if (m_waited > 0) begin
                if (dmem_ack)                          m_waited = 0;
                else if (m_waited >= int'(MEM_TIMEOUT)) begin m_err = 1'b1; m_waited = 0; end
                else                                   m_waited++;
            end else if (memop && !dmem_ack) begin
                m_waited = 1;
            end
        end
    endtask

    // One clock cycle: compare mid-cycle, then advance model at the edge
    task automatic step(input bit do_chk);
        logic [10:0] e;
        #2;
        e = model_ctrl();
        if (do_chk) begin
            chk("ctrl", 32'({dmem_req, Pcsrc, PcWr, IfIdWr, IfIdFlush, IdExWr, IdExFlush,
                             ExMemWr, MemWbFlush, err}), 32'(e));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        end
        @(posedge clk);
        model_clock(e[7]);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [5:0] eop, input logic [4:0] ert, input logic ez,
                         input logic [5:0] mop, input logic ack);
        Op = op; Rs = rs; Rt = rt; eOp = eop; eRt = ert; eZ = ez; mOp = mop; dmem_ack = ack;
    endtask

    task automatic do_reset();
        drive(OP_R, 5'd0, 5'd0, OP_R, 5'd0, 1'b0, OP_R, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        step(1);
    endtask

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 7))
            0: return OP_R;
            1: return OP_BEQ;
            2: return OP_BNE;
            3: return OP_J;
            4: return OP_LW;
            5: return OP_SW;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        rst = 1'b1;
        drive(OP_R, 5'd0, 5'd0, OP_R, 5'd0, 1'b0, OP_R, 1'b0);
        step(0);
        rst = 1'b0;
        step(1);
        step(1);
        chk("boot_cnt_zero", 32'(stall_cnt), 32'd0);
        step(1);

        // Branch beats jump; BNE with zero flag is not taken
        drive(OP_J, 5'd0, 5'd0, OP_BEQ, 5'd0, 1'b1, OP_R, 1'b0); step(1);
        drive(OP_R, 5'd0, 5'd0, OP_BNE, 5'd0, 1'b1, OP_R, 1'b0); step(1);

        // Load-use bubble, x0 destination and jump cases
        drive(OP_R, 5'd0, 5'd5, OP_LW, 5'd5, 1'b0, OP_R, 1'b0); step(1);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        drive(OP_R, 5'd0, 5'd5, OP_R, 5'd0, 1'b0, OP_R, 1'b0);  step(1);
        drive(OP_R, 5'd0, 5'd5, OP_LW, 5'd0, 1'b0, OP_R, 1'b0); step(1);
        drive(OP_J, 5'd5, 5'd0, OP_LW, 5'd0, 1'b0, OP_R, 1'b0); step(1);
        chk("lu_cnt_hold", 32'(stall_cnt), 32'd1);

        // Store with three wait cycles then ack
        do_reset();
        drive(OP_R, 5'd0, 5'd0, OP_R, 5'd0, 1'b0, OP_SW, 1'b0);
        repeat (3) step(1);
        dmem_ack = 1'b1;
        step(1);
        chk("sw_cnt", 32'(stall_cnt), 32'd3);

        // Load never acknowledged: timeout into the error state, reset exits
        do_reset();
        drive(OP_R, 5'd0, 5'd0, OP_R, 5'd0, 1'b0, OP_LW, 1'b0);
        repeat (7) step(1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_req", 32'(dmem_req), 32'd0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_err", 32'(err), 32'd0);
        step(1);
        step(1);

        // Continuous load-use saturates the stall counter
        do_reset();
        drive(OP_R, 5'd0, 5'd5, OP_LW, 5'd5, 1'b0, OP_R, 1'b0);
        repeat (20) step(1);
        chk("sat_cnt", 32'(stall_cnt), 32'd15);

        // Random traffic with periodic ack droughts to reach timeout
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive(rand_op(), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  rand_op(), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  rand_op(), ((i % 150) < 12) ? 1'b0 : 1'($urandom_range(0, 2) != 0));
            step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
